// File: rtl/adjacency_query_arbiter.sv
// Shares the adjacency_map query/reply port between NUM_REQ requesters, one
// query+reply-burst transaction at a time. Define ADJ_ARB_FIXED_PRIORITY_EN for fixed priority.
module adjacency_query_arbiter #(
    parameter int  NODE_WIDTH = 10,
    parameter int  NUM_REQ    = 2,
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_query_valid,
    input  logic [NUM_REQ*NODE_WIDTH-1:0] req_query_data,
    output logic [NUM_REQ-1:0]            req_query_ready,
    output logic [NUM_REQ-1:0]            req_reply_valid,
    input  logic [NUM_REQ-1:0]            req_reply_ready,
    output logic                          req_reply_last,
    output logic [NODE_WIDTH-1:0]         req_reply_data,
    output logic                          req_reply_no_edges_found,
    input  logic                          map_query_ready,
    output logic                          map_query_valid,
    output logic [NODE_WIDTH-1:0]         map_query_data,
    output logic                          map_reply_ready,
    input  logic                          map_reply_valid,
    input  logic                          map_reply_last,
    input  logic [NODE_WIDTH-1:0]         map_reply_data,
    input  logic                          map_reply_no_edges_found,
    output logic [IDX_W-1:0]              grant_idx,
    output logic                          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        REPLY = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [NODE_WIDTH-1:0] query_q, query_d;
    logic [IDX_W-1:0]      rr_next;
    logic [IDX_W:0]        cand;
    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;

    // In fixed-priority mode the pointer never moves, so the search always starts at 0.
`ifdef ADJ_ARB_FIXED_PRIORITY_EN
    assign rr_next = '0;
`else
    assign rr_next = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
`endif

    // Rotating search: walk offsets from the far end so the nearest active request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
            cand = (cand >= (IDX_W + 1)'(NUM_REQ)) ? cand - (IDX_W + 1)'(NUM_REQ) : cand;
            if (req_query_valid[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end else begin
                win_found = win_found;
            end
        end
    end

    // Next-state and handshake steering.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_d         = grant_q;
        query_d         = query_q;
        req_query_ready = '0;
        req_reply_valid = '0;
        map_reply_ready = 1'b0;
        map_query_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    req_query_ready[win_idx] = 1'b1;
                    query_d = req_query_data[win_idx*NODE_WIDTH +: NODE_WIDTH];
                    grant_d = win_idx;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                map_query_valid = 1'b1;
                if (map_query_ready) begin
                    state_d = REPLY;
                end else begin
                    state_d = ISSUE;
                end
            end
            REPLY: begin
                req_reply_valid[grant_q] = map_reply_valid;
                map_reply_ready          = req_reply_ready[grant_q];
                // Either flag ends the burst; an empty list never carries last.
                if (map_reply_valid && req_reply_ready[grant_q] &&
                    (map_reply_last || map_reply_no_edges_found)) begin
                    rr_ptr_d = rr_next;
                    state_d  = IDLE;
                end else begin
                    state_d = REPLY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and transaction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            query_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            query_q  <= query_d;
        end
    end

    assign map_query_data           = query_q;
    assign req_reply_data           = map_reply_data;
    assign req_reply_last           = map_reply_last;
    assign req_reply_no_edges_found = map_reply_no_edges_found;
    assign grant_idx                = grant_q;
    assign busy                     = (state_q != IDLE);

endmodule

// File: tb/tb_adjacency_query_arbiter.sv
// Directed self-checking bench for adjacency_query_arbiter (NUM_REQ=2, NODE_WIDTH=10).
module tb_adjacency_query_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] rqv, rqr, rrv, rrr;
    logic [19:0] rqd;
    logic       rlast, rne, mqr, mqv, mrr, mrv, mlast, mne, busy;
    logic [9:0] rdata, mqd, mdata;
    logic [0:0] gidx;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adjacency_query_arbiter #(.NODE_WIDTH(10), .NUM_REQ(2)) dut (
        .clk(clk), .rst(rst),
        .req_query_valid(rqv), .req_query_data(rqd), .req_query_ready(rqr),
        .req_reply_valid(rrv), .req_reply_ready(rrr), .req_reply_last(rlast),
        .req_reply_data(rdata), .req_reply_no_edges_found(rne),
        .map_query_ready(mqr), .map_query_valid(mqv), .map_query_data(mqd),
        .map_reply_ready(mrr), .map_reply_valid(mrv), .map_reply_last(mlast),
        .map_reply_data(mdata), .map_reply_no_edges_found(mne),
        .grant_idx(gidx), .busy(busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rqv = 2'b00; rqd = 20'h0; rrr = 2'b00; mqr = 1'b0;
        mrv = 1'b0; mlast = 1'b0; mne = 1'b0; mdata = 10'h0;
    endtask

    // Waits for a query accept (bounded), returns the winner or -1, and steps past the grant edge.
    task automatic acquire(output int w);
        w = -1;
        for (int i = 0; i < 16 && w < 0; i++) begin
            #1;
            if (rqr != 2'b00) w = rqr[1] ? 1 : 0;
            cyc();
        end
    endtask

    task automatic issue(output bit ok);
        ok  = 1'b0;
        mqr = 1'b1;
        for (int i = 0; i < 16 && !ok; i++) begin
            #1;
            if (mqv) ok = 1'b1;
            cyc();
        end
        mqr = 1'b0;
    endtask

    task automatic beat(input logic [9:0] d, input logic lst, input logic ne,
                        output logic [1:0] v, output logic [9:0] dout);
        mrv = 1'b1; mdata = d; mlast = lst; mne = ne; rrr = 2'b11;
        #1;
        v = rrv; dout = rdata;
        cyc();
        mrv = 1'b0; mlast = 1'b0; mne = 1'b0; rrr = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        mdata = 10'h155; mlast = 1'b1; mne = 1'b1;
        cyc(); cyc();
        checks++; if (rqr !== 2'b00) begin errors++; $display("FAIL reset_qready got %b want 00", rqr); end
        checks++; if (rrv !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b want 00", rrv); end
        checks++; if (mqv !== 1'b0) begin errors++; $display("FAIL reset_mqvalid got %b want 0", mqv); end
        checks++; if (mrr !== 1'b0) begin errors++; $display("FAIL reset_mrready got %b want 0", mrr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (gidx !== 1'b0) begin errors++; $display("FAIL reset_grant got %b want 0", gidx); end
        checks++; if (rdata !== 10'h155 || rlast !== 1'b1 || rne !== 1'b1) begin
            errors++; $display("FAIL reset_passthru got %h/%b/%b want 155/1/1", rdata, rlast, rne); end
        rst = 1'b0;
        idle_inputs();
        cyc();
    endtask

    task automatic test_single();
        logic [9:0] exp_d [3] = '{10'd7, 10'd9, 10'd12};
        logic [1:0] v;
        logic [9:0] d;
        bit ok;
        int pulses = 0;
        rqv = 2'b01; rqd = {10'd0, 10'd5};
        #1;
        checks++; if (rqr !== 2'b01) begin errors++; $display("FAIL single_qready got %b want 01", rqr); end
        cyc();
        rqv = 2'b00;
        #1;
        checks++; if (mqv !== 1'b1 || mqd !== 10'd5) begin
            errors++; $display("FAIL single_issue got %b/%0d want 1/5", mqv, mqd); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        issue(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_issue_timeout got 0 want 1"); end
        for (int b = 0; b < 3; b++) begin
            beat(exp_d[b], (b == 2), 1'b0, v, d);
            if (v == 2'b01) pulses++;
            checks++; if (v !== 2'b01 || d !== exp_d[b]) begin
                errors++; $display("FAIL single_beat%0d got %b/%0d want 01/%0d", b, v, d, exp_d[b]); end
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL single_pulses got %0d want 3", pulses); end
        checks++; if (busy !== 1'b0 || gidx !== 1'b0) begin
            errors++; $display("FAIL single_done got busy=%b grant=%b want 0/0", busy, gidx); end
    endtask

    task automatic test_simultaneous();
        int w, exp_w;
        bit ok;
        logic [1:0] v;
        logic [9:0] d;
        rst = 1'b1; idle_inputs(); cyc(); rst = 1'b0;
        rqv = 2'b11; rqd = {10'd20, 10'd10};
        for (int t = 0; t < 4; t++) begin
`ifdef ADJ_ARB_FIXED_PRIORITY_EN
            exp_w = 0;
`else
            exp_w = t % 2;
`endif
            acquire(w);
            checks++; if (w != exp_w) begin errors++; $display("FAIL simul_grant%0d got %0d want %0d", t, w, exp_w); end
            issue(ok);
            checks++; if (!ok) begin errors++; $display("FAIL simul_issue%0d got timeout want handshake", t); end
            beat(10'd0, 1'b0, 1'b1, v, d);
            checks++; if (v !== (2'b01 << exp_w)) begin
                errors++; $display("FAIL simul_rvalid%0d got %b want %b", t, v, 2'b01 << exp_w); end
        end
        rqv = 2'b00;
    endtask

    task automatic test_backpressure();
        logic [9:0] exp_d [2] = '{10'h011, 10'h022};
        int w, k;
        bit ok;
        logic tog;
        rqv = 2'b11; rqd = {10'h01B, 10'h02A};
        acquire(w);
        checks++; if (w != 0) begin errors++; $display("FAIL bp_grant got %0d want 0", w); end
        rqd[9:0] = 10'h3C0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (mqv !== 1'b1 || mqd !== 10'h02A) begin
                errors++; $display("FAIL bp_hold%0d got %b/%h want 1/02a", i, mqv, mqd); end
            checks++; if (rqr !== 2'b00) begin errors++; $display("FAIL bp_qready%0d got %b want 00", i, rqr); end
            cyc();
        end
        issue(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_issue got timeout want handshake"); end
        k = 0; tog = 1'b0;
        for (int c = 0; c < 12 && k < 2; c++) begin
            mrv = 1'b1; mdata = exp_d[k]; mlast = (k == 1); rrr = {1'b1, tog};
            #1;
            checks++; if (rrv !== 2'b01 || gidx !== 1'b0 || mrr !== tog) begin
                errors++; $display("FAIL bp_steer%0d got rv=%b g=%b mrr=%b want 01/0/%b", c, rrv, gidx, mrr, tog); end
            if (rrv[0] && rrr[0]) begin
                checks++; if (rdata !== exp_d[k]) begin
                    errors++; $display("FAIL bp_data%0d got %h want %h", k, rdata, exp_d[k]); end
                k++;
            end
            cyc();
            tog = ~tog;
        end
        mrv = 1'b0; mlast = 1'b0; rrr = 2'b00; rqv = 2'b00;
        checks++; if (k != 2) begin errors++; $display("FAIL bp_beats got %0d want 2", k); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_done got busy=%b want 0", busy); end
    endtask

    task automatic test_empty_list();
        int w, exp_w;
        bit ok;
        logic [1:0] v;
        logic [9:0] d;
        rqv = 2'b01; rqd = {10'h000, 10'h3FF};
        acquire(w);
        rqv = 2'b00;
        checks++; if (w != 0 || mqd !== 10'h3FF) begin
            errors++; $display("FAIL empty_grant got %0d/%h want 0/3ff", w, mqd); end
        issue(ok);
        beat(10'h000, 1'b0, 1'b1, v, d);
        checks++; if (v !== 2'b01 || busy !== 1'b0) begin
            errors++; $display("FAIL empty_term got rv=%b busy=%b want 01/0", v, busy); end
`ifdef ADJ_ARB_FIXED_PRIORITY_EN
        exp_w = 0;
`else
        exp_w = 1;
`endif
        rqv = 2'b11;
        acquire(w);
        checks++; if (w != exp_w) begin errors++; $display("FAIL empty_next got %0d want %0d", w, exp_w); end
        issue(ok);
        beat(10'h000, 1'b0, 1'b1, v, d);
        rqv = 2'b00;
    endtask

    task automatic test_reset_mid_reply();
        int w;
        bit ok;
        logic [1:0] v;
        logic [9:0] d;
        rqv = 2'b01; rqd = {10'd33, 10'd44};
        acquire(w); issue(ok); beat(10'd0, 1'b0, 1'b1, v, d);
        rqv = 2'b10;
        acquire(w);
        checks++; if (w != 1) begin errors++; $display("FAIL rmid_grant got %0d want 1", w); end
        issue(ok);
        beat(10'd1, 1'b0, 1'b0, v, d);
        checks++; if (v !== 2'b10 || d !== 10'd1) begin
            errors++; $display("FAIL rmid_beat got %b/%0d want 10/1", v, d); end
        rqv = 2'b00; mrv = 1'b1; mdata = 10'd2; rrr = 2'b11; rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (rqr !== 2'b00 || rrv !== 2'b00 || mqv !== 1'b0 || mrr !== 1'b0) begin
            errors++; $display("FAIL rmid_outputs got %b/%b/%b/%b want 00/00/0/0", rqr, rrv, mqv, mrr); end
        checks++; if (busy !== 1'b0 || gidx !== 1'b0) begin
            errors++; $display("FAIL rmid_state got busy=%b grant=%b want 0/0", busy, gidx); end
        idle_inputs();
        rqv = 2'b11; rqd = {10'd55, 10'd66};
        acquire(w);
        checks++; if (w != 0) begin errors++; $display("FAIL rmid_rrptr got grant %0d want 0", w); end
        issue(ok); beat(10'd0, 1'b0, 1'b1, v, d);
        rqv = 2'b10;
        acquire(w);
        rqv = 2'b00;
        checks++; if (w != 1 || mqd !== 10'd55) begin
            errors++; $display("FAIL rmid_fresh got %0d/%0d want 1/55", w, mqd); end
        issue(ok);
        beat(10'd8, 1'b0, 1'b0, v, d);
        checks++; if (v !== 2'b10 || d !== 10'd8) begin errors++; $display("FAIL rmid_b0 got %b/%0d want 10/8", v, d); end
        beat(10'd9, 1'b1, 1'b0, v, d);
        checks++; if (v !== 2'b10 || d !== 10'd9 || busy !== 1'b0) begin
            errors++; $display("FAIL rmid_b1 got %b/%0d/%b want 10/9/0", v, d, busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_empty_list();
        test_reset_mid_reply();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
